// File: rtl/tt_rvv_pkg.sv
// Shared RVV mask/reduction definitions: sequencer state encoding and width helpers.
package tt_rvv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCnt,
    StRsp
  } seq_state_e;

  // Width needed to hold a value in 0..vlen inclusive.
  function automatic int unsigned vl_width(input int unsigned vlen);
    return $clog2(vlen) + 1;
  endfunction

endpackage

// File: rtl/tt_popcnt.sv
// Combinational population count of a WIDTH-bit word.
module tt_popcnt #(
  parameter int unsigned WIDTH = 64,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + CNT_W'(i_data[i]);
    end
  end

endmodule

// File: rtl/tt_vcpop_seq.sv
// vcpop.m sequencer: masks the source by v0 and vl, then counts it CHUNK bits per beat
// through one shared popcount, returning the total over a valid/ready response.
module tt_vcpop_seq
  import tt_rvv_pkg::*;
#(
  parameter int unsigned VLEN  = 256,
  parameter int unsigned CHUNK = 64,
  localparam int unsigned NBEAT = VLEN / CHUNK,
  localparam int unsigned VL_W  = vl_width(VLEN)
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [VL_W-1:0] i_req_vl,
  input  logic            i_req_vm,
  input  logic [VLEN-1:0] i_req_src,
  input  logic [VLEN-1:0] i_req_v0,
  input  logic            i_kill,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [VL_W-1:0] o_rsp_count
);

  localparam int unsigned BEAT_W    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int unsigned CNT_W     = $clog2(CHUNK) + 1;
  localparam int unsigned CHUNK_LOG = $clog2(CHUNK);

  seq_state_e        state_q, state_d;
  logic [VLEN-1:0]   mask_q, mask_d;
  logic [VL_W-1:0]   acc_q, acc_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] last_q, last_d;

  logic [VL_W-1:0]  vl_eff;
  logic [VL_W-1:0]  vl_m1;
  logic [VLEN-1:0]  tail;
  logic [VLEN-1:0]  v0_sel;
  logic [CHUNK-1:0] chunk;
  logic [CNT_W-1:0] chunk_cnt;

  always_comb begin
    vl_eff = (i_req_vl > VL_W'(VLEN)) ? VL_W'(VLEN) : i_req_vl;
    vl_m1  = vl_eff - VL_W'(1);
    v0_sel = i_req_vm ? {VLEN{1'b1}} : i_req_v0;
    for (int i = 0; i < VLEN; i++) begin
      tail[i] = vl_eff > VL_W'(i);
    end
  end

  assign chunk = mask_q[beat_q*CHUNK +: CHUNK];

  tt_popcnt #(
    .WIDTH (CHUNK)
  ) u_popcnt (
    .i_data  (chunk),
    .o_count (chunk_cnt)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    last_d  = last_q;
    if (i_kill) begin
      state_d = StIdle;
      acc_d   = '0;
      beat_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_req_valid) begin
            mask_d  = i_req_src & v0_sel & tail;
            // Index of the final beat; unused when vl_eff is zero.
            last_d  = BEAT_W'(vl_m1 >> CHUNK_LOG);
            acc_d   = '0;
            beat_d  = '0;
            state_d = (vl_eff == '0) ? StRsp : StCnt;
          end
        end
        StCnt: begin
          acc_d = acc_q + VL_W'(chunk_cnt);
          if (beat_q == last_q) begin
            state_d = StRsp;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
        StRsp: begin
          if (i_rsp_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
    end
  end

  assign o_req_ready = (state_q == StIdle);
  assign o_rsp_valid = (state_q == StRsp);
  assign o_rsp_count = acc_q;

endmodule

// File: tb/tb_tt_vcpop_seq.sv
// Directed self-checking bench for tt_vcpop_seq (VLEN=256, CHUNK=64).
module tb_tt_vcpop_seq;

  localparam int unsigned VLEN = 256;
  localparam int unsigned VL_W = 9;

  logic            i_clk;
  logic            i_reset_n;
  logic            i_req_valid;
  logic            o_req_ready;
  logic [VL_W-1:0] i_req_vl;
  logic            i_req_vm;
  logic [VLEN-1:0] i_req_src;
  logic [VLEN-1:0] i_req_v0;
  logic            i_kill;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [VL_W-1:0] o_rsp_count;

  int errors;
  int checks;
  int lat;
  int held_count;
  logic [VLEN-1:0] ones;
  logic [VLEN-1:0] f0s;
  logic [VLEN-1:0] fives;
  logic [VLEN-1:0] ff8;
  logic [VLEN-1:0] b64_65;

  tt_vcpop_seq #(
    .VLEN  (256),
    .CHUNK (64)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_vl    (i_req_vl),
    .i_req_vm    (i_req_vm),
    .i_req_src   (i_req_src),
    .i_req_v0    (i_req_v0),
    .i_kill      (i_kill),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_count (o_rsp_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one request for one edge, then count edges until rsp valid (accept edge = 1).
  task automatic run_req(input logic [VL_W-1:0] vl, input logic vm, input logic [VLEN-1:0] src,
                         input logic [VLEN-1:0] v0, output int n);
    i_req_valid = 1'b1;
    i_req_vl    = vl;
    i_req_vm    = vm;
    i_req_src   = src;
    i_req_v0    = v0;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    n = 1;
    while (!o_rsp_valid && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
  endtask

  task automatic take_rsp();
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    ones        = '1;
    f0s         = {32{8'hF0}};
    fives       = {64{4'h5}};
    ff8         = VLEN'(8'hFF);
    b64_65      = '0;
    b64_65[64]  = 1'b1;
    b64_65[65]  = 1'b1;
    i_reset_n   = 1'b0;
    i_req_valid = 1'b0;
    i_req_vl    = '0;
    i_req_vm    = 1'b1;
    i_req_src   = '0;
    i_req_v0    = '0;
    i_kill      = 1'b0;
    i_rsp_ready = 1'b0;
    #12;
    check("reset_req_ready", int'(o_req_ready), 1);
    check("reset_rsp_valid", int'(o_rsp_valid), 0);
    check("reset_rsp_count", int'(o_rsp_count), 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Full vector, unmasked
    run_req(9'd256, 1'b1, ones, '0, lat);
    check("full_lat", lat, 5);
    check("full_count", int'(o_rsp_count), 256);
    take_rsp();
    check("full_ready_after", int'(o_req_ready), 1);
    check("full_valid_after", int'(o_rsp_valid), 0);

    // Tail masking, two beats
    run_req(9'd70, 1'b1, ones, '0, lat);
    check("vl70_lat", lat, 3);
    check("vl70_count", int'(o_rsp_count), 70);
    take_rsp();

    // Bits 64/65 with vl=65: only bit 64 is active
    run_req(9'd65, 1'b1, b64_65, '0, lat);
    check("vl65_count", int'(o_rsp_count), 1);
    take_rsp();

    // v0 masking
    run_req(9'd256, 1'b0, ones, fives, lat);
    check("v0_lat", lat, 5);
    check("v0_count", int'(o_rsp_count), 128);
    take_rsp();

    // vl=0
    run_req(9'd0, 1'b1, ones, '0, lat);
    check("vl0_lat", lat, 1);
    check("vl0_count", int'(o_rsp_count), 0);
    take_rsp();

    // vl clamp
    run_req(9'd300, 1'b1, f0s, '0, lat);
    check("clamp_lat", lat, 5);
    check("clamp_count", int'(o_rsp_count), 128);

    // Hold response with a competing request pending
    held_count  = 0;
    i_req_valid = 1'b1;
    i_req_vl    = 9'd8;
    i_req_src   = ff8;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      #1;
      if (o_rsp_valid === 1'b1 && o_rsp_count === 9'd128 && o_req_ready === 1'b0) held_count++;
    end
    check("hold_cycles", held_count, 10);
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rsp_ready = 1'b0;
    i_req_valid = 1'b0;
    check("hs_no_accept_ready", int'(o_req_ready), 1);
    check("hs_no_accept_valid", int'(o_rsp_valid), 0);
    @(posedge i_clk);
    #1;
    check("hs_idle_after", int'(o_req_ready), 1);

    // Kill in the second CNT cycle
    i_req_valid = 1'b1;
    i_req_vl    = 9'd256;
    i_req_vm    = 1'b1;
    i_req_src   = ones;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_kill = 1'b1;
    @(posedge i_clk);
    #1;
    i_kill = 1'b0;
    check("kill_ready", int'(o_req_ready), 1);
    check("kill_count", int'(o_rsp_count), 0);
    held_count = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk);
      #1;
      if (o_rsp_valid === 1'b1) held_count++;
    end
    check("kill_no_stale", held_count, 0);

    // Request alongside kill is not accepted
    i_req_valid = 1'b1;
    i_kill      = 1'b1;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_kill      = 1'b0;
    check("kill_req_dropped", int'(o_req_ready), 1);

    run_req(9'd8, 1'b1, ff8, '0, lat);
    check("post_kill_lat", lat, 2);
    check("post_kill_count", int'(o_rsp_count), 8);
    take_rsp();

    // Async reset mid-op
    run_req(9'd256, 1'b1, ones, '0, lat);
    take_rsp();
    i_req_valid = 1'b1;
    i_req_vl    = 9'd256;
    i_req_src   = ones;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b0;
    #1;
    check("arst_ready", int'(o_req_ready), 1);
    check("arst_valid", int'(o_rsp_valid), 0);
    check("arst_count", int'(o_rsp_count), 0);
    #1;
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("arst_no_rsp", int'(o_rsp_valid), 0);
    run_req(9'd8, 1'b1, ff8, '0, lat);
    check("post_rst_count", int'(o_rsp_count), 8);
    take_rsp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
